// File: rtl/mem_access_ctrl.sv
// Shared RAM port sequencer: arbitrates fetch vs data load/store
// and strobes MAR/MDR/RAM controls with a fixed wait-state count.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clock,
    input  logic clear,
    input  logic fetch_req,
    input  logic data_rd_req,
    input  logic data_wr_req,
    output logic grant_fetch,
    output logic grant_data,
    output logic MARin,
    output logic MDRin,
    output logic Read,
    output logic ram_rd,
    output logic ram_wr,
    output logic fetch_done,
    output logic data_done,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_MEM,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_gnt_data;
    logic       r_op_wr;
    logic       r_last_was_data;
    logic [3:0] r_wait_cnt;
    logic       w_data_pend;
    logic       w_any_req;
    logic       w_pick_data;

    assign w_data_pend = data_rd_req | data_wr_req;
    assign w_any_req   = fetch_req | w_data_pend;
    // On contention, data wins unless it was the side served last
    assign w_pick_data = w_data_pend & (~fetch_req | ~r_last_was_data);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_gnt_data      <= 1'b0;
            r_op_wr         <= 1'b0;
            r_last_was_data <= 1'b0;
            r_wait_cnt      <= 4'd0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_gnt_data <= w_pick_data;
                r_op_wr    <= w_pick_data & data_wr_req;
            end
            if (r_state == S_DONE) begin
                r_last_was_data <= r_gnt_data;
            end
            if (w_next == S_MEM && r_state != S_MEM) begin
                r_wait_cnt <= WAIT_INIT;
            end else if (r_state == S_MEM && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = w_any_req ? S_ADDR : S_IDLE;
            S_ADDR:    w_next = r_op_wr ? S_WDATA : S_MEM;
            S_WDATA:   w_next = S_MEM;
            S_MEM: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next = r_op_wr ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        Read        = 1'b0;
        ram_rd      = 1'b0;
        ram_wr      = 1'b0;
        fetch_done  = 1'b0;
        data_done   = 1'b0;
        busy        = 1'b0;
        if (r_state != S_IDLE) begin
            busy        = 1'b1;
            grant_fetch = ~r_gnt_data;
            grant_data  = r_gnt_data;
        end
        unique case (r_state)
            S_IDLE:  ;
            S_ADDR:  MARin = 1'b1;
            S_WDATA: MDRin = 1'b1;
            S_MEM: begin
                ram_rd = ~r_op_wr;
                ram_wr = r_op_wr;
            end
            S_CAPTURE: begin
                MDRin  = 1'b1;
                Read   = 1'b1;
                ram_rd = 1'b1;
            end
            S_DONE: begin
                fetch_done = ~r_gnt_data;
                data_done  = r_gnt_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small MAR/MDR/RAM
// environment and hand-written per-cycle output tables.
module tb_mem_access_ctrl;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic fetch_req = 1'b0;
    logic data_rd_req = 1'b0;
    logic data_wr_req = 1'b0;
    logic grant_fetch, grant_data, MARin, MDRin, Read;
    logic ram_rd, ram_wr, fetch_done, data_done, busy;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] pc = 32'h0;
    logic [31:0] daddr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] bus;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] ram [0:255];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h0;
    logic [31:0] ld_data = 32'h0;
    logic [9:0]  obs;

    always #5 clock = ~clock;

    mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .clock(clock),
        .clear(clear),
        .fetch_req(fetch_req),
        .data_rd_req(data_rd_req),
        .data_wr_req(data_wr_req),
        .grant_fetch(grant_fetch),
        .grant_data(grant_data),
        .MARin(MARin),
        .MDRin(MDRin),
        .Read(Read),
        .ram_rd(ram_rd),
        .ram_wr(ram_wr),
        .fetch_done(fetch_done),
        .data_done(data_done),
        .busy(busy)
    );

    // {gf, gd, MARin, MDRin, Read, ram_rd, ram_wr, fdone, ddone, busy}
    assign obs = {grant_fetch, grant_data, MARin, MDRin, Read,
                  ram_rd, ram_wr, fetch_done, data_done, busy};

    always_comb begin
        bus = 32'h0;
        if (grant_fetch) bus = pc;
        else if (grant_data) bus = MARin ? daddr : wdata;
    end

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            mar <= 32'h0;
            mdr <= 32'h0;
        end else begin
            if (MARin) mar <= bus;
            if (MDRin) mdr <= Read ? ram[mar[7:0]] : bus;
        end
    end

    always @(posedge clock) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (!clear && ram_wr) ram[mar[7:0]] <= mdr;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] ev [3] = '{10'b0000000000, 10'b0110000001,
                               10'b0101000001};
        clear = 1'b1;
        fetch_req = 1'b1;
        data_rd_req = 1'b1;
        data_wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== 10'b0) begin
                n_fail++;
                $display("FAIL reset_outputs c%0d got %b want %b", i, obs, 10'b0);
            end
        end
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL reset_release c%0d got %b want %b", i, obs, ev[i]);
            end
        end
        clear = 1'b1;
        fetch_req = 1'b0;
        data_rd_req = 1'b0;
        data_wr_req = 1'b0;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        logic [9:0] ev [7] = '{10'b0000000000, 10'b1010000001,
                               10'b1000010001, 10'b1000010001,
                               10'b1001110001, 10'b1000000101,
                               10'b0000000000};
        ld_en = 1'b1;
        ld_addr = 8'h10;
        ld_data = 32'hDEADBEEF;
        tick();
        ld_en = 1'b0;
        pc = 32'h10;
        fetch_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if (i == 6) fetch_req = 1'b0;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL fetch c%0d got %b want %b", i, obs, ev[i]);
            end
            if (i == 5) begin
                n_checks++;
                if (mdr !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL fetch_mdr got %h want %h", mdr, 32'hDEADBEEF);
                end
            end
        end
    endtask

    task automatic test_store();
        logic [9:0] ev [7] = '{10'b0000000000, 10'b0110000001,
                               10'b0101000001, 10'b0100001001,
                               10'b0100001001, 10'b0100000011,
                               10'b0000000000};
        tick();
        daddr = 32'h20;
        wdata = 32'h1234ABCD;
        data_wr_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if (i == 6) data_wr_req = 1'b0;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL store c%0d got %b want %b", i, obs, ev[i]);
            end
        end
        n_checks++;
        if (ram[8'h20] !== 32'h1234ABCD) begin
            n_fail++;
            $display("FAIL store_ram got %h want %h", ram[8'h20], 32'h1234ABCD);
        end
    endtask

    task automatic test_load();
        logic [9:0] ev [7] = '{10'b0000000000, 10'b0110000001,
                               10'b0100010001, 10'b0100010001,
                               10'b0101110001, 10'b0100000011,
                               10'b0000000000};
        tick();
        daddr = 32'h20;
        wdata = 32'h0;
        data_rd_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if (i == 6) data_rd_req = 1'b0;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL load c%0d got %b want %b", i, obs, ev[i]);
            end
            if (i == 5) begin
                n_checks++;
                if (mdr !== 32'h1234ABCD) begin
                    n_fail++;
                    $display("FAIL load_mdr got %h want %h", mdr, 32'h1234ABCD);
                end
            end
        end
    endtask

    task automatic test_contention();
        int nd = 0;
        int last_c = 0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        pc = 32'h10;
        daddr = 32'h20;
        fetch_req = 1'b1;
        data_rd_req = 1'b1;
        for (int c = 1; c <= 60 && nd < 4; c++) begin
            tick();
            n_checks++;
            if (grant_fetch && grant_data) begin
                n_fail++;
                $display("FAIL contention_overlap c%0d got 11 want not both", c);
            end
            if (fetch_done || data_done) begin
                n_checks++;
                if (data_done !== ((nd % 2) == 0) || fetch_done === data_done) begin
                    n_fail++;
                    $display("FAIL contention_order #%0d got fd=%b dd=%b want dd=%0d",
                             nd, fetch_done, data_done, (nd % 2) == 0);
                end
                n_checks++;
                if (mdr !== (data_done ? 32'h1234ABCD : 32'hDEADBEEF)) begin
                    n_fail++;
                    $display("FAIL contention_mdr #%0d got %h", nd, mdr);
                end
                if (nd > 0) begin
                    n_checks++;
                    if (c - last_c != 6) begin
                        n_fail++;
                        $display("FAIL contention_gap got %0d want 6", c - last_c);
                    end
                end
                last_c = c;
                nd++;
                if (nd == 4) begin
                    fetch_req = 1'b0;
                    data_rd_req = 1'b0;
                end
            end
        end
        n_checks++;
        if (nd != 4) begin
            n_fail++;
            $display("FAIL contention_count got %0d want 4", nd);
            fetch_req = 1'b0;
            data_rd_req = 1'b0;
        end
        tick();
    endtask

    task automatic test_simul_rdwr();
        int nd = 0;
        int nf = 0;
        logic saw_wr = 1'b0;
        tick();
        daddr = 32'h30;
        wdata = 32'hCAFEF00D;
        data_rd_req = 1'b1;
        data_wr_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ram_wr) saw_wr = 1'b1;
            if (fetch_done) nf++;
            if (data_done) begin
                nd++;
                if (nd == 1) begin
                    n_checks++;
                    if (saw_wr !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rdwr_store_first got wr=%b want 1", saw_wr);
                    end
                    data_wr_req = 1'b0;
                end else begin
                    n_checks++;
                    if (saw_wr !== 1'b0 || mdr !== 32'hCAFEF00D) begin
                        n_fail++;
                        $display("FAIL rdwr_load got wr=%b mdr=%h want 0 %h",
                                 saw_wr, mdr, 32'hCAFEF00D);
                    end
                    data_rd_req = 1'b0;
                end
                saw_wr = 1'b0;
            end
        end
        n_checks++;
        if (nd != 2 || nf != 0) begin
            n_fail++;
            $display("FAIL rdwr_count got dd=%0d fd=%0d want 2 0", nd, nf);
        end
        data_rd_req = 1'b0;
        data_wr_req = 1'b0;
    endtask

    task automatic test_abort();
        int ndone = 0;
        tick();
        daddr = 32'h20;
        data_rd_req = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (obs !== 10'b0100010001) begin
            n_fail++;
            $display("FAIL abort_pre got %b want %b", obs, 10'b0100010001);
        end
        #2;
        clear = 1'b1;
        #1;
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL abort_now got %b want %b", obs, 10'b0);
        end
        data_rd_req = 1'b0;
        repeat (3) begin
            tick();
            if (fetch_done || data_done || busy) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL abort_quiet got %0d want 0", ndone);
        end
        clear = 1'b0;
        pc = 32'h10;
        fetch_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) begin
                n_checks++;
                if (obs !== 10'b1010000001) begin
                    n_fail++;
                    $display("FAIL abort_refetch_addr got %b want %b", obs, 10'b1010000001);
                end
            end
        end
        n_checks++;
        if (obs !== 10'b1000000101 || mdr !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL abort_refetch_done got %b %h want %b %h",
                     obs, mdr, 10'b1000000101, 32'hDEADBEEF);
        end
        fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_contention();
        test_simul_rdwr();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
